// File: rtl/imm_decode_pipe_if.sv
// Handshake bundle for imm_decode_pipe: upstream instruction side and
// downstream decoded-immediate side.
interface imm_decode_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [2:0]      imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [31:0]     out_instr;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, imm_src, out_ready,
        input  in_ready, out_valid, out_imm, out_instr, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, imm_src, out_ready,
        output in_ready, out_valid, out_imm, out_instr, out_illegal
    );
endinterface

// File: rtl/imm_decode_pipe.sv
// Immediate decoder with a registered output stage and a one-entry skid
// buffer so in_ready never depends combinationally on out_ready.
module imm_decode_pipe #(
    parameter int XLEN     = 32,
    parameter bit AUTO_SRC = 1'b0
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    imm_decode_pipe_if.slave bus
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_Z = 3'd5;
    localparam logic [2:0] FMT_X = 3'd6;

    logic [31:0]     ins;
    logic [2:0]      fmt;
    logic [63:0]     imm_wide;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    logic [31:0]     main_instr_q, main_instr_d;
    logic            main_illegal_q, main_illegal_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            skid_illegal_q, skid_illegal_d;

    logic in_ready;
    logic in_fire;
    logic out_fire;

    assign ins = bus.in_instr;

    // Immediates are built at 64 bits and truncated, which sign-extends from bit 31 for either XLEN.
    always_comb begin
        fmt = bus.imm_src;
        if (AUTO_SRC) begin
            case (ins[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
                7'b0100011:                         fmt = FMT_S;
                7'b1100011:                         fmt = FMT_B;
                7'b0110111, 7'b0010111:             fmt = FMT_U;
                7'b1101111:                         fmt = FMT_J;
                7'b1110011:                         fmt = ins[14] ? FMT_Z : FMT_I;
                default:                            fmt = FMT_X;
            endcase
        end

        dec_illegal = 1'b0;
        imm_wide    = 64'd0;
        case (fmt)
            FMT_I: imm_wide = {{52{ins[31]}}, ins[31:20]};
            FMT_S: imm_wide = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B: imm_wide = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U: imm_wide = {{32{ins[31]}}, ins[31:12], 12'd0};
            FMT_J: imm_wide = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_Z: imm_wide = {59'd0, ins[19:15]};
            default: dec_illegal = 1'b1;
        endcase
        dec_imm = imm_wide[XLEN-1:0];
    end

    assign in_ready = ~skid_valid_q & ~rst;
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = main_valid_q & bus.out_ready;

    always_comb begin
        main_valid_d   = main_valid_q;
        main_imm_d     = main_imm_q;
        main_instr_d   = main_instr_q;
        main_illegal_d = main_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_instr_d   = skid_instr_q;
        skid_illegal_d = skid_illegal_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            // A full skid blocks in_ready, so it and a new input never compete for main.
            if (skid_valid_q) begin
                main_valid_d   = 1'b1;
                main_imm_d     = skid_imm_q;
                main_instr_d   = skid_instr_q;
                main_illegal_d = skid_illegal_q;
                skid_valid_d   = 1'b0;
            end else if (in_fire) begin
                main_valid_d   = 1'b1;
                main_imm_d     = dec_imm;
                main_instr_d   = ins;
                main_illegal_d = dec_illegal;
            end else begin
                main_valid_d   = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = dec_imm;
            skid_instr_d   = ins;
            skid_illegal_d = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q   <= 1'b0;
            main_imm_q     <= '0;
            main_instr_q   <= '0;
            main_illegal_q <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_instr_q   <= '0;
            skid_illegal_q <= 1'b0;
        end else begin
            main_valid_q   <= main_valid_d;
            main_imm_q     <= main_imm_d;
            main_instr_q   <= main_instr_d;
            main_illegal_q <= main_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_instr_q   <= skid_instr_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_imm     = main_imm_q;
    assign bus.out_instr   = main_instr_q;
    assign bus.out_illegal = main_illegal_q;

endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter AUTO_SRC, default 0; 1 = derive immediate format from opcode, 0 = use imm_src input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-008 SHALL have port in_instr  input  32  raw instruction word.
REQ-009 SHALL have port imm_src  input  3  format select (I=0, S=1, B=2, U=3, J=4, Z=5); ignored when AUTO_SRC=1.
REQ-010 SHALL have port out_valid  output  1  output entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-013 SHALL have port out_instr  output  32  instruction carried with out_imm.
REQ-014 SHALL have port out_illegal  output  1  format unresolvable; out_imm is 0.

Function
REQ-015 SHALL transfer input when in_valid & in_ready and output when out_valid & out_ready on the same edge.
REQ-016 SHALL register the result: an entry accepted at edge N appears on out_* after edge N (latency 1) when the output stage is empty or draining.
REQ-017 SHALL hold a main register plus one skid register; in_ready = skid register empty, driven from a flop only (no combinational path from out_ready).
REQ-018 SHALL, when output stalled (out_valid & !out_ready) and an input is accepted, store it in the skid register; skid moves to main on the next output transfer.
REQ-019 SHALL keep out_* stable while out_valid & !out_ready.
REQ-020 SHALL preserve order; no entry dropped or duplicated except by flush/rst.
REQ-021 SHALL form immediates: I = sext(instr[31:20]); S = sext(instr[31:25],instr[11:7]); B = sext(instr[31],instr[7],instr[30:25],instr[11:8],0); U = sext(instr[31:12],12'b0); J = sext(instr[31],instr[19:12],instr[20],instr[30:21],0); Z = zext(instr[19:15]); sign-extension to XLEN from bit 31 of the sign source.
REQ-022 SHALL, with AUTO_SRC=1, map opcode: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 1110011 with funct3[2]=1 -> Z, funct3[2]=0 -> I.
REQ-023 SHALL, for imm_src 6/7 (AUTO_SRC=0) or unmapped opcode (AUTO_SRC=1), set out_illegal=1 and out_imm=0; entry still transfers normally.
REQ-024 SHALL, on flush, clear main and skid valid at that edge; inputs offered that cycle are dropped; in_ready=1 the next cycle.
REQ-025 SHALL give flush priority over simultaneous input/output transfers.

Reset
REQ-026 SHALL, while rst high, force in_ready=0 and ignore in_valid.
REQ-027 SHALL, after the reset edge, hold out_valid=0, out_imm=0, out_instr=0, out_illegal=0, skid empty; in_ready=1 the cycle after rst deasserts.
REQ-028 SHALL, on rst mid-transfer, discard both entries with no partial output.

Verification
REQ-029 SHALL check: XLEN=32, AUTO_SRC=1, in 0xFFF00093, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
REQ-030 SHALL check: AUTO_SRC=1, in 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC; in 0x300FD073 (csrrwi zimm 31) -> out_imm=0x0000001F.
REQ-031 SHALL check: XLEN=64, in 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000; in 0x123450B7 -> 0x0000000012345000.
REQ-032 SHALL check: out_ready=0, two back-to-back inputs A,B -> in_ready=0 after B, out holds A; out_ready=1 -> A then B on consecutive cycles, in_ready returns 1.
REQ-033 SHALL check: full skid, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and offered entries never appear.
REQ-034 SHALL check: AUTO_SRC=0, imm_src=7 -> out_illegal=1, out_imm=0; rst asserted with out_valid=1 -> out_valid=0 after edge.
